// File: rtl/fractal_pkg.sv
// fractal_pkg
// Shared definitions for the fractal view controller: Q3.13 format constants,
// command encodings, controller state encoding, reset view defaults, the view
// parameter bundle and a saturating narrow-to-Q3.13 helper.
package fractal_pkg;

  localparam int Q_WIDTH   = 16;
  localparam int Q_FRAC    = 13;
  localparam int PAN_SHIFT = 5;

  localparam logic [Q_WIDTH-1:0] DEF_HOME_X   = 16'hE000;
  localparam logic [Q_WIDTH-1:0] DEF_HOME_Y   = 16'hE000;
  localparam logic [Q_WIDTH-1:0] DEF_HOME_SX  = 16'h0019;
  localparam logic [Q_WIDTH-1:0] DEF_HOME_SY  = 16'h0022;
  localparam logic [Q_WIDTH-1:0] DEF_STEP_MAX = 16'h0400;

  typedef enum logic [2:0] {
    OP_PAN_LEFT  = 3'd0,
    OP_PAN_RIGHT = 3'd1,
    OP_PAN_UP    = 3'd2,
    OP_PAN_DOWN  = 3'd3,
    OP_ZOOM_IN   = 3'd4,
    OP_ZOOM_OUT  = 3'd5,
    OP_HOME      = 3'd6,
    OP_REDRAW    = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_ARM   = 3'd2,
    ST_KICK  = 3'd3,
    ST_BUSY  = 3'd4
  } view_state_e;

  // All four fields are signed Q3.13; kept as raw bits and reinterpreted where needed.
  typedef struct packed {
    logic [Q_WIDTH-1:0] start_x;
    logic [Q_WIDTH-1:0] start_y;
    logic [Q_WIDTH-1:0] step_x;
    logic [Q_WIDTH-1:0] step_y;
  } view_t;

  // Clamp a wide signed intermediate to the Q3.13 range.
  function automatic logic [Q_WIDTH-1:0] sat_q(input logic signed [25:0] v);
    if (v > 26'sd32767)
      return 16'h7FFF;
    else if (v < -26'sd32768)
      return 16'h8000;
    else
      return v[Q_WIDTH-1:0];
  endfunction

  function automatic logic [Q_WIDTH-1:0] sat_p17(input logic [16:0] v);
    return sat_q({{9{v[16]}}, v});
  endfunction

endpackage

// File: rtl/fractal_view_math.sv
// fractal_view_math
// Purely combinational view update: given a command and the current view
// parameters, produce the next view parameters and whether the command is legal.
// Ports:
//   op    - command opcode
//   cur   - current startX/startY/stepX/stepY
//   nxt   - updated parameters (equal to cur when the command is illegal)
//   legal - 1 when the command may be applied
module fractal_view_math
  import fractal_pkg::*;
#(
  parameter logic [Q_WIDTH-1:0] HOME_X   = DEF_HOME_X,
  parameter logic [Q_WIDTH-1:0] HOME_Y   = DEF_HOME_Y,
  parameter logic [Q_WIDTH-1:0] HOME_SX  = DEF_HOME_SX,
  parameter logic [Q_WIDTH-1:0] HOME_SY  = DEF_HOME_SY,
  parameter logic [Q_WIDTH-1:0] STEP_MAX = DEF_STEP_MAX
) (
  input  cmd_op_e op,
  input  view_t   cur,
  output view_t   nxt,
  output logic    legal
);

  // Zoom products of a full-range step need up to ~24 bits; 26 leaves headroom.
  localparam int W = 26;

  logic [16:0]         x17, y17, pan_dx, pan_dy;
  logic [16:0]         pan_xl, pan_xr, pan_yu, pan_yd;
  logic signed [W-1:0] x_w, y_w, sx_w, sy_w;
  logic signed [W-1:0] zin_x, zin_y, zout_x, zout_y;
  logic                zin_ok, zout_ok;

  assign x17    = {cur.start_x[Q_WIDTH-1], cur.start_x};
  assign y17    = {cur.start_y[Q_WIDTH-1], cur.start_y};
  assign pan_dx = {cur.step_x[Q_WIDTH-1], cur.step_x} << PAN_SHIFT;
  assign pan_dy = {cur.step_y[Q_WIDTH-1], cur.step_y} << PAN_SHIFT;

  assign pan_xl = x17 - pan_dx;
  assign pan_xr = x17 + pan_dx;
  assign pan_yu = y17 - pan_dy;
  assign pan_yd = y17 + pan_dy;

  assign x_w  = {{(W-Q_WIDTH){cur.start_x[Q_WIDTH-1]}}, cur.start_x};
  assign y_w  = {{(W-Q_WIDTH){cur.start_y[Q_WIDTH-1]}}, cur.start_y};
  assign sx_w = {{(W-Q_WIDTH){cur.step_x[Q_WIDTH-1]}}, cur.step_x};
  assign sy_w = {{(W-Q_WIDTH){cur.step_y[Q_WIDTH-1]}}, cur.step_y};

  // Recentre on zoom: 160 = 128+32, 120 = 128-8, 320 = 256+64, 240 = 256-16.
  assign zin_x  = x_w + ((sx_w <<< 7) + (sx_w <<< 5));
  assign zin_y  = y_w + ((sy_w <<< 7) - (sy_w <<< 3));
  assign zout_x = x_w - ((sx_w <<< 8) + (sx_w <<< 6));
  assign zout_y = y_w - ((sy_w <<< 8) - (sy_w <<< 4));

  assign zin_ok  = ($signed(cur.step_x) >= 16'sd2) && ($signed(cur.step_y) >= 16'sd2);
  assign zout_ok = ($signed(cur.step_x) <= $signed(STEP_MAX >> 1)) &&
                   ($signed(cur.step_y) <= $signed(STEP_MAX >> 1));

  always_comb begin
    nxt   = cur;
    legal = 1'b1;
    case (op)
      OP_PAN_LEFT:  nxt.start_x = sat_p17(pan_xl);
      OP_PAN_RIGHT: nxt.start_x = sat_p17(pan_xr);
      OP_PAN_UP:    nxt.start_y = sat_p17(pan_yu);
      OP_PAN_DOWN:  nxt.start_y = sat_p17(pan_yd);
      OP_ZOOM_IN: begin
        legal = zin_ok;
        if (zin_ok) begin
          nxt.start_x = sat_q(zin_x);
          nxt.start_y = sat_q(zin_y);
          nxt.step_x  = {cur.step_x[Q_WIDTH-1], cur.step_x[Q_WIDTH-1:1]};
          nxt.step_y  = {cur.step_y[Q_WIDTH-1], cur.step_y[Q_WIDTH-1:1]};
        end
      end
      OP_ZOOM_OUT: begin
        legal = zout_ok;
        if (zout_ok) begin
          nxt.start_x = sat_q(zout_x);
          nxt.start_y = sat_q(zout_y);
          nxt.step_x  = {cur.step_x[Q_WIDTH-2:0], 1'b0};
          nxt.step_y  = {cur.step_y[Q_WIDTH-2:0], 1'b0};
        end
      end
      OP_HOME: begin
        nxt.start_x = HOME_X;
        nxt.start_y = HOME_Y;
        nxt.step_x  = HOME_SX;
        nxt.step_y  = HOME_SY;
      end
      OP_REDRAW: nxt = cur;
    endcase
  end

endmodule

// File: rtl/fractal_view_ctrl.sv
// fractal_view_ctrl
// Accepts pan/zoom/home/redraw commands, updates a shadow copy of the view,
// and publishes it to the fractal engine together with a start pulse during
// vertical blanking. The visible parameters only change on the start cycle.
// Ports:
//   Clk_100M, reset          - clock, synchronous active-high reset
//   cmd_valid/cmd_op/cmd_ready - command handshake
//   vblank, frac_done        - engine timing inputs
//   frac_start               - one-cycle frame start
//   startX/startY/stepX/stepY - visible Q3.13 view parameters
//   busy, cmd_err            - status; cmd_err pulses on a rejected command
//
// state | meaning
// IDLE  | waiting for a command, outputs stable
// APPLY | compute new view into shadow, or reject the command
// ARM   | waiting for vblank
// KICK  | publish shadow, pulse frac_start
// BUSY  | engine rendering, waiting for frac_done
module fractal_view_ctrl
  import fractal_pkg::*;
#(
  parameter logic [Q_WIDTH-1:0] HOME_X   = DEF_HOME_X,
  parameter logic [Q_WIDTH-1:0] HOME_Y   = DEF_HOME_Y,
  parameter logic [Q_WIDTH-1:0] HOME_SX  = DEF_HOME_SX,
  parameter logic [Q_WIDTH-1:0] HOME_SY  = DEF_HOME_SY,
  parameter logic [Q_WIDTH-1:0] STEP_MAX = DEF_STEP_MAX
) (
  input  logic                      Clk_100M,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic [2:0]                cmd_op,
  output logic                      cmd_ready,
  input  logic                      vblank,
  input  logic                      frac_done,
  output logic                      frac_start,
  output logic signed [Q_WIDTH-1:0] startX,
  output logic signed [Q_WIDTH-1:0] startY,
  output logic signed [Q_WIDTH-1:0] stepX,
  output logic signed [Q_WIDTH-1:0] stepY,
  output logic                      busy,
  output logic                      cmd_err
);

  localparam view_t HOME_VIEW = '{start_x: HOME_X, start_y: HOME_Y,
                                  step_x: HOME_SX, step_y: HOME_SY};

  view_state_e state_q, state_nxt;
  cmd_op_e     op_q;
  view_t       shadow_q, view_q, math_nxt;
  logic        math_legal;
  logic        op_ld, shadow_ld, view_ld;

  fractal_view_math #(
    .HOME_X   (HOME_X),
    .HOME_Y   (HOME_Y),
    .HOME_SX  (HOME_SX),
    .HOME_SY  (HOME_SY),
    .STEP_MAX (STEP_MAX)
  ) u_math (
    .op    (op_q),
    .cur   (shadow_q),
    .nxt   (math_nxt),
    .legal (math_legal)
  );

  // Reset parks in ARM so the first frame starts by itself at vblank.
  always_ff @(posedge Clk_100M) begin
    if (reset)
      state_q <= ST_ARM;
    else
      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid && cmd_ready) state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = math_legal ? ST_ARM : ST_IDLE;
      ST_ARM:   if (vblank) state_nxt = ST_KICK;
      ST_KICK:  state_nxt = ST_BUSY;
      ST_BUSY:  if (frac_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_ARM;
    endcase
  end

  // Status outputs are gated by reset so they read correctly while it is held.
  always_comb begin
    cmd_ready  = (state_q == ST_IDLE) && !reset;
    busy       = (state_q != ST_IDLE) || reset;
    frac_start = (state_q == ST_KICK) && !reset;
    cmd_err    = (state_q == ST_APPLY) && !math_legal && !reset;
    op_ld      = cmd_valid && cmd_ready;
    shadow_ld  = (state_q == ST_APPLY) && math_legal;
    // Load on the ARM->KICK edge so new values are visible during the KICK cycle.
    view_ld    = (state_q == ST_ARM) && vblank;
  end

  always_ff @(posedge Clk_100M) begin
    if (reset) begin
      op_q     <= OP_REDRAW;
      shadow_q <= HOME_VIEW;
      view_q   <= HOME_VIEW;
    end else begin
      if (op_ld)     op_q     <= cmd_op_e'(cmd_op);
      if (shadow_ld) shadow_q <= math_nxt;
      if (view_ld)   view_q   <= shadow_q;
    end
  end

  assign startX = view_q.start_x;
  assign startY = view_q.start_y;
  assign stepX  = view_q.step_x;
  assign stepY  = view_q.step_y;

endmodule

// File: tb/tb_fractal_view_ctrl.sv
// tb_fractal_view_ctrl
// Self-checking bench: directed scenarios plus randomized command streams,
// compared against an integer-arithmetic model of the view rules.
module tb_fractal_view_ctrl;

  logic               Clk_100M = 1'b0;
  logic               reset, cmd_valid, cmd_ready, vblank, frac_done;
  logic               frac_start, busy, cmd_err;
  logic [2:0]         cmd_op;
  logic signed [15:0] startX, startY, stepX, stepY;

  int n_vec = 0;
  int n_err = 0;

  // Reference view, plain signed integers.
  int mx, my, msx, msy;

  always #5 Clk_100M = ~Clk_100M;

  fractal_view_ctrl dut (
    .Clk_100M   (Clk_100M),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .vblank     (vblank),
    .frac_done  (frac_done),
    .frac_start (frac_start),
    .startX     (startX),
    .startY     (startY),
    .stepX      (stepX),
    .stepY      (stepY),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_home();
    mx = -8192; my = -8192; msx = 25; msy = 34;
  endfunction

  // Returns legality; updates the model only when legal.
  function automatic bit model_apply(input logic [2:0] op);
    case (op)
      3'd0: mx = clamp16(mx - msx * 32);
      3'd1: mx = clamp16(mx + msx * 32);
      3'd2: my = clamp16(my - msy * 32);
      3'd3: my = clamp16(my + msy * 32);
      3'd4: begin
        if (msx < 2 || msy < 2) return 1'b0;
        mx = clamp16(mx + msx * 160);
        my = clamp16(my + msy * 120);
        msx = msx / 2;
        msy = msy / 2;
      end
      3'd5: begin
        if (msx > 512 || msy > 512) return 1'b0;
        mx = clamp16(mx - msx * 320);
        my = clamp16(my - msy * 240);
        msx = msx * 2;
        msy = msy * 2;
      end
      3'd6: model_home();
      default: ;
    endcase
    return 1'b1;
  endfunction

  task automatic check_view(input string tag);
    check({tag, "_x"},  {16'h0, startX}, mx  & 'hFFFF);
    check({tag, "_y"},  {16'h0, startY}, my  & 'hFFFF);
    check({tag, "_sx"}, {16'h0, stepX},  msx & 'hFFFF);
    check({tag, "_sy"}, {16'h0, stepY},  msy & 'hFFFF);
  endtask

  task automatic check_const(input string tag, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] sx, input logic [15:0] sy);
    check({tag, "_x"},  {16'h0, startX}, {16'h0, x});
    check({tag, "_y"},  {16'h0, startY}, {16'h0, y});
    check({tag, "_sx"}, {16'h0, stepX},  {16'h0, sx});
    check({tag, "_sy"}, {16'h0, stepY},  {16'h0, sy});
  endtask

  // Reset with vblank high, expect exactly one automatic home frame. Ends in IDLE at a negedge.
  task automatic reset_kick();
    int kicks;
    reset = 1; vblank = 1; cmd_valid = 0; frac_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk_100M);
      check("rst_start", frac_start, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_busy",  busy, 1);
      check("rst_err",   cmd_err, 0);
    end
    check_const("rst_view", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
    reset = 0;
    model_home();
    kicks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk_100M);
      if (frac_start) begin
        kicks++;
        check_const("rst_kick", 16'hE000, 16'hE000, 16'h0019, 16'h0022);
      end
      check("rst_busy_run", busy, 1);
    end
    check("rst_kick_cnt", kicks, 1);
    vblank = 0;
    frac_done = 1;
    @(negedge Clk_100M);
    frac_done = 0;
    check("rst_idle", busy, 0);
  endtask

  // Called with cmd_valid already high in IDLE (accepted at the next edge).
  task automatic after_accept(input logic [2:0] op, input int vb_wait, input bit done_at_kick,
                              input int busy_len, input bit hold_next, input logic [2:0] next_op,
                              input bit abort);
    bit legal;
    int px, psx, cyc, exp_cyc;
    bit seen;
    px = mx; psx = msx;
    legal = model_apply(op);
    @(negedge Clk_100M);
    cmd_valid = 0;
    check("apply_busy", busy, 1);
    check("apply_err", cmd_err, !legal);
    check("apply_hold_x",  {16'h0, startX}, px & 'hFFFF);
    check("apply_hold_sx", {16'h0, stepX},  psx & 'hFFFF);
    if (!legal) begin
      @(negedge Clk_100M);
      check("rej_busy", busy, 0);
      check("rej_err", cmd_err, 0);
      check("rej_start", frac_start, 0);
      check_view("rej_view");
      return;
    end
    vblank = (vb_wait == 0);
    @(negedge Clk_100M);
    check("arm_nostart", frac_start, 0);
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      if (frac_start) seen = 1;
      else begin
        cyc++;
        if (cyc >= vb_wait) vblank = 1;
        @(negedge Clk_100M);
      end
    end
    if (!seen) begin
      check("kick_timeout", 0, 1);
      vblank = 0;
      return;
    end
    exp_cyc = (vb_wait == 0) ? 1 : vb_wait;
    check("kick_latency", cyc, exp_cyc);
    check_view("kick_view");
    check("kick_ready", cmd_ready, 0);
    vblank = 0;
    frac_done = done_at_kick;
    @(negedge Clk_100M);
    frac_done = 0;
    check("busy_start", frac_start, 0);
    check("busy_flag", busy, 1);
    if (hold_next) begin
      cmd_valid = 1;
      cmd_op = next_op;
    end
    for (int i = 0; i < busy_len; i++) begin
      @(negedge Clk_100M);
      check("busy_hold", busy, 1);
      check("busy_stall", cmd_ready, 0);
      check("busy_x", {16'h0, startX}, mx & 'hFFFF);
    end
    if (abort) return;
    frac_done = 1;
    @(negedge Clk_100M);
    frac_done = 0;
    check("done_idle", busy, 0);
    check("done_ready", cmd_ready, 1);
  endtask

  task automatic send(input logic [2:0] op, input int vb_wait, input bit done_at_kick,
                      input int busy_len, input bit hold_next, input logic [2:0] next_op,
                      input bit abort);
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_op = op;
    after_accept(op, vb_wait, done_at_kick, busy_len, hold_next, next_op, abort);
  endtask

  initial begin
    reset = 1; vblank = 1; cmd_valid = 0; cmd_op = 3'd0; frac_done = 0;
    model_home();
    reset_kick();

    send(3'd4, 0, 0, 1, 0, 3'd0, 0);
    check_const("zin_home", 16'hEFA0, 16'hEFF0, 16'h000C, 16'h0011);

    send(3'd6, 1, 0, 0, 0, 3'd0, 0);
    send(3'd5, 2, 1, 1, 0, 3'd0, 0);
    check_const("zout_home", 16'hC0C0, 16'hC020, 16'h0032, 16'h0044);

    send(3'd6, 0, 0, 0, 0, 3'd0, 0);
    send(3'd1, 0, 0, 0, 0, 3'd0, 0);
    check("pan_right_x", {16'h0, startX}, 32'h0000E320);
    for (int i = 0; i < 60; i++) send(3'd0, 0, 0, 0, 0, 3'd0, 0);
    check("pan_sat_x", {16'h0, startX}, 32'h00008000);

    send(3'd6, 0, 0, 0, 0, 3'd0, 0);
    for (int i = 0; i < 5; i++) send(3'd4, 0, 0, 0, 0, 3'd0, 0);
    check("zin5_sx", {16'h0, stepX}, 32'h00000001);
    check("zin5_sy", {16'h0, stepY}, 32'h00000002);

    // Stray frac_done while idle.
    frac_done = 1;
    @(negedge Clk_100M);
    frac_done = 0;
    check("stray_busy", busy, 0);
    check("stray_ready", cmd_ready, 1);
    @(negedge Clk_100M);
    check("stray_busy2", busy, 0);
    check_view("stray_view");

    // Command held through BUSY is stalled, then taken right after frac_done.
    send(3'd2, 0, 0, 3, 1, 3'd3, 0);
    after_accept(3'd3, 1, 0, 1, 0, 3'd0, 0);

    // Reset in the middle of a frame.
    send(3'd5, 0, 0, 2, 0, 3'd0, 1);
    reset_kick();
    check_const("rst_mid", 16'hE000, 16'hE000, 16'h0019, 16'h0022);

    for (int i = 0; i < 150; i++) begin
      send(3'($urandom_range(7)), int'($urandom_range(3)), 1'($urandom_range(1)),
           int'($urandom_range(3)), 0, 3'd0, 0);
    end
    check_view("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_view_ctrl.md
FRACTAL_VIEW_CTRL -- requirements
Module: fractal_view_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- HOME_X, 16'hE000, reset startX (Q3.13)
- HOME_Y, 16'hE000, reset startY
- HOME_SX, 16'h0019, reset stepX
- HOME_SY, 16'h0022, reset stepY
- STEP_MAX, 16'h0400, largest legal step
REQ-002 The design SHALL use one clock; reset is synchronous and active-high. Ports are listed as name, direction, width, meaning:
- Clk_100M, in, 1, clock
- reset, in, 1, synchronous active-high reset
REQ-003 Command ports SHALL be:
- cmd_valid, in, 1, command offered
- cmd_op, in, 3, 0 pan-left, 1 pan-right, 2 pan-up, 3 pan-down, 4 zoom-in, 5 zoom-out, 6 home, 7 redraw
- cmd_ready, out, 1, command accepted when high with cmd_valid
REQ-004 Engine ports SHALL be:
- vblank, in, 1, level, high during vertical blanking
- frac_done, in, 1, one-cycle pulse, frame finished
- frac_start, out, 1, one-cycle start pulse to the fractal engine
- startX, startY, stepX, stepY, out, 16 each, signed Q3.13 view parameters
- busy, out, 1, high in all states except IDLE
- cmd_err, out, 1, one-cycle pulse, command rejected

Function
REQ-005 The FSM SHALL have states IDLE, APPLY, ARM, KICK and BUSY.
REQ-006 Transitions SHALL be:
- IDLE→APPLY on cmd_valid&cmd_ready
- APPLY→ARM if the command is legal, else APPLY→IDLE with cmd_err=1
- ARM→KICK when vblank=1
- KICK→BUSY unconditionally
- BUSY→IDLE on frac_done
REQ-007 cmd_ready SHALL be high only in IDLE; commands offered in other states SHALL stall, not drop.
REQ-008 In APPLY, shadow registers SHALL be loaded from fractal_view_math output; visible outputs SHALL remain unchanged.
REQ-009 In KICK, frac_start SHALL be 1 for exactly one cycle, and startX/startY/stepX/stepY SHALL load from shadow in that same cycle.
REQ-010 Outputs SHALL hold constant through BUSY and IDLE.
REQ-011 Pan SHALL add or subtract (step<<5) of the matching axis to the matching start: left/up subtract, right/down add.
REQ-012 Pan arithmetic SHALL be computed in 17 bits and saturated to 16'h8000/16'h7FFF; a saturated pan is legal.
REQ-013 Zoom-in SHALL set step'=step>>1 and start'=start+step*160 (X) or start+step*120 (Y); constant multiplies use shift-add, and arithmetic saturates as in REQ-012.
REQ-014 Zoom-in SHALL be illegal if stepX<2 or stepY<2.
REQ-015 Zoom-out SHALL set step'=step<<1 and start'=start−step*320 (X) or start−step*240 (Y), with saturation.
REQ-016 Zoom-out SHALL be illegal if stepX>STEP_MAX>>1 or stepY>STEP_MAX>>1.
REQ-017 Home SHALL load the HOME_* values; redraw SHALL keep the current values; both are always legal.
REQ-018 An illegal command SHALL leave shadow and outputs unchanged and start no frame.
REQ-019 frac_done outside BUSY SHALL be ignored.
REQ-020 frac_done coincident with the KICK cycle SHALL be ignored.
REQ-021 If vblank is already high on entry to ARM, KICK SHALL follow in the next cycle.
REQ-022 Latency SHALL be: accept at cycle N, APPLY at N+1, ARM at N+2, frac_start no earlier than N+3.

Reset
REQ-023 While reset=1, outputs SHALL take HOME_*, with frac_start=0, cmd_err=0, cmd_ready=0 and busy=1.
REQ-024 The state SHALL go to ARM, so that the first frame after reset starts automatically at vblank.
REQ-025 Reset asserted in any state, including BUSY mid-frame, SHALL abandon the command and restore REQ-023/024 on the next edge.

Structure
REQ-026 Shared package fractal_pkg SHALL hold:
- the Q3.13 width/fraction constants
- the cmd_op encodings
- the FSM state enum
- the default HOME_* and STEP_MAX values
- the pan shift constant (5)
REQ-027 One combinational sub-module fractal_view_math SHALL map (op, current params) to (next params, legal); the FSM and registers SHALL stay in fractal_view_ctrl.

Verification
REQ-028 Reset release with vblank=1 SHALL give one frac_start pulse, with outputs E000/E000/0019/0022 and busy=1 until frac_done.
REQ-029 From home, zoom-in SHALL give startX=EFA0, startY=EFF0, stepX=000C, stepY=0011 at the frac_start cycle.
REQ-030 From home, zoom-out SHALL give startX=C0C0, startY=C020, stepX=0032, stepY=0044.
REQ-031 From home, pan-right SHALL give startX=E320; 60 pan-lefts SHALL saturate startX at 8000 with no wrap.
REQ-032 Five zoom-ins SHALL leave stepX=0000 never reached; the fifth zoom-in (stepX=1) SHALL pulse cmd_err, produce no frac_start and keep the outputs.
REQ-033 The following SHALL hold:
- cmd_valid held during BUSY is stalled (cmd_ready=0) and accepted the cycle after frac_done
- a stray frac_done in IDLE causes no state change
- reset mid-BUSY restores home and re-kicks
